// File: rtl/br_rs_pkg.sv
// Shared types for the branch reservation station: CPU widths, branch opcodes,
// the dispatched uop, the queue entry and the issue packet handed to fu_br.
package br_rs_pkg;

    localparam int XLEN       = 32;
    localparam int PRF_IDX_W  = 6;
    localparam int ROB_IDX_W  = 5;
    localparam int ARCH_IDX_W = 5;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5,
        BR_JAL  = 3'd6,
        BR_JALR = 3'd7
    } br_op_e;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [PRF_IDX_W-1:0]  rd_phy;
        logic [PRF_IDX_W-1:0]  rs1_phy;
        logic [PRF_IDX_W-1:0]  rs2_phy;
        logic                  rs1_rdy;
        logic                  rs2_rdy;
        br_op_e                fu_opcode;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic                  predict_taken;
        logic [XLEN-1:0]       predict_target;
    } br_uop_t;

    typedef struct packed {
        logic    valid;
        logic    rs1_rdy;
        logic    rs2_rdy;
        br_uop_t uop;
    } br_rs_entry_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_id;
        logic [ARCH_IDX_W-1:0] rd_arch;
        logic [PRF_IDX_W-1:0]  rd_phy;
        br_op_e                fu_opcode;
        logic [XLEN-1:0]       rs1_value;
        logic [XLEN-1:0]       rs2_value;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        logic                  predict_taken;
        logic [XLEN-1:0]       predict_target;
    } fu_br_reg_t;

    localparam int BR_UOP_W    = $bits(br_uop_t);
    localparam int FU_BR_REG_W = $bits(fu_br_reg_t);

    function automatic fu_br_reg_t pack_fu_br(input br_uop_t u,
                                              input logic [XLEN-1:0] rs1_value,
                                              input logic [XLEN-1:0] rs2_value);
        fu_br_reg_t r;
        r.rob_id         = u.rob_id;
        r.rd_arch        = u.rd_arch;
        r.rd_phy         = u.rd_phy;
        r.fu_opcode      = u.fu_opcode;
        r.rs1_value      = rs1_value;
        r.rs2_value      = rs2_value;
        r.imm            = u.imm;
        r.pc             = u.pc;
        r.predict_taken  = u.predict_taken;
        r.predict_target = u.predict_target;
        return r;
    endfunction

endpackage

// File: rtl/br_rs_if.sv
// Dispatch, wakeup, PRF-read and issue signals of the branch reservation station.
// The slave side is the station itself; the master side is the surrounding backend.
interface br_rs_if #(
    parameter int NUM_CDB = 4
);
    import br_rs_pkg::*;

    logic                           flush;
    logic                           dispatch_valid;
    logic                           dispatch_ready;
    br_uop_t                        dispatch_uop;
    logic [NUM_CDB-1:0]             cdb_valid;
    logic [NUM_CDB*PRF_IDX_W-1:0]   cdb_rd_phy;
    logic [PRF_IDX_W-1:0]           prf_rs1_idx;
    logic [PRF_IDX_W-1:0]           prf_rs2_idx;
    logic [XLEN-1:0]                prf_rs1_data;
    logic [XLEN-1:0]                prf_rs2_data;
    logic                           br_rs_valid;
    logic                           fu_br_ready;
    fu_br_reg_t                     fu_br_reg_out;

    modport slave (
        input  flush, dispatch_valid, dispatch_uop, cdb_valid, cdb_rd_phy,
               prf_rs1_data, prf_rs2_data, fu_br_ready,
        output dispatch_ready, prf_rs1_idx, prf_rs2_idx, br_rs_valid, fu_br_reg_out
    );

    modport master (
        output flush, dispatch_valid, dispatch_uop, cdb_valid, cdb_rd_phy,
               prf_rs1_data, prf_rs2_data, fu_br_ready,
        input  dispatch_ready, prf_rs1_idx, prf_rs2_idx, br_rs_valid, fu_br_reg_out
    );

endinterface

// File: rtl/br_rs.sv
// In-order reservation station for branch/jump uops: circular queue with CDB
// wakeup, issuing only from the head with operands read from the PRF at issue.
module br_rs
    import br_rs_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int NUM_CDB = 4
) (
    input  logic    clk,
    input  logic    rst,
    br_rs_if.slave  bus
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

    br_rs_entry_t       ent [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W:0]     count;

    logic [DEPTH-1:0]   wake1;
    logic [DEPTH-1:0]   wake2;
    logic               disp_hit1;
    logic               disp_hit2;
    logic               disp_rs1_rdy;
    logic               disp_rs2_rdy;
    logic               do_disp;
    logic               do_issue;
    logic               unused_rdy;

    // Per-entry wakeup: any valid CDB port naming the entry's source marks it ready.
    for (genvar e = 0; e < DEPTH; e++) begin : g_wake
        logic hit1;
        logic hit2;
        always_comb begin
            hit1 = 1'b0;
            hit2 = 1'b0;
            for (int i = 0; i < NUM_CDB; i++) begin
                if (bus.cdb_valid[i] && bus.cdb_rd_phy[i*PRF_IDX_W +: PRF_IDX_W] == ent[e].uop.rs1_phy)
                    hit1 = 1'b1;
                if (bus.cdb_valid[i] && bus.cdb_rd_phy[i*PRF_IDX_W +: PRF_IDX_W] == ent[e].uop.rs2_phy)
                    hit2 = 1'b1;
            end
        end
        assign wake1[e] = ent[e].valid && hit1;
        assign wake2[e] = ent[e].valid && hit2;
    end

    always_comb begin
        disp_hit1 = 1'b0;
        disp_hit2 = 1'b0;
        for (int i = 0; i < NUM_CDB; i++) begin
            if (bus.cdb_valid[i] && bus.cdb_rd_phy[i*PRF_IDX_W +: PRF_IDX_W] == bus.dispatch_uop.rs1_phy)
                disp_hit1 = 1'b1;
            if (bus.cdb_valid[i] && bus.cdb_rd_phy[i*PRF_IDX_W +: PRF_IDX_W] == bus.dispatch_uop.rs2_phy)
                disp_hit2 = 1'b1;
        end
    end

    // Physical register 0 is hardwired zero, so it never needs a wakeup.
    assign disp_rs1_rdy = bus.dispatch_uop.rs1_rdy || (bus.dispatch_uop.rs1_phy == '0) || disp_hit1;
    assign disp_rs2_rdy = bus.dispatch_uop.rs2_rdy || (bus.dispatch_uop.rs2_phy == '0) || disp_hit2;

    assign bus.dispatch_ready = (count != FULL_CNT);
    assign do_disp            = bus.dispatch_valid && bus.dispatch_ready && !bus.flush;

    assign bus.br_rs_valid   = ent[head].valid && ent[head].rs1_rdy && ent[head].rs2_rdy && !bus.flush;
    assign do_issue          = bus.br_rs_valid && bus.fu_br_ready;
    assign bus.prf_rs1_idx   = ent[head].uop.rs1_phy;
    assign bus.prf_rs2_idx   = ent[head].uop.rs2_phy;
    assign bus.fu_br_reg_out = pack_fu_br(ent[head].uop, bus.prf_rs1_data, bus.prf_rs2_data);

    // Live readiness is tracked in the entry bits; the uop copies are dispatch-time only.
    assign unused_rdy = ent[head].uop.rs1_rdy ^ ent[head].uop.rs2_rdy;

    // Queue state: flush shares the reset path and overrides dispatch, issue and wakeup.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ent[e].valid   <= 1'b0;
                ent[e].rs1_rdy <= 1'b0;
                ent[e].rs2_rdy <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wake1[e]) ent[e].rs1_rdy <= 1'b1;
                if (wake2[e]) ent[e].rs2_rdy <= 1'b1;
            end
            if (do_issue) begin
                ent[head].valid <= 1'b0;
                head            <= head + PTR_ONE;
            end
            if (do_disp) begin
                ent[tail].valid   <= 1'b1;
                ent[tail].rs1_rdy <= disp_rs1_rdy;
                ent[tail].rs2_rdy <= disp_rs2_rdy;
                ent[tail].uop     <= bus.dispatch_uop;
                tail              <= tail + PTR_ONE;
            end
            if (do_disp && !do_issue)
                count <= count + CNT_ONE;
            else if (do_issue && !do_disp)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= FULL_CNT);
            assert (!(do_disp && count == FULL_CNT));
            assert (count == '0 || ent[head].valid);
        end
    end

endmodule

// File: tb/tb_br_rs.sv
// Directed bench for br_rs: cycle-by-cycle vector table plus a mid-stream reset sequence.
module tb_br_rs;
    import br_rs_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    br_rs_if #(.NUM_CDB(4)) bus ();

    br_rs #(.DEPTH(4), .NUM_CDB(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PRF model: data is a recognisable function of the read index.
    assign bus.prf_rs1_data = 32'hA000_0000 | {26'd0, bus.prf_rs1_idx};
    assign bus.prf_rs2_data = 32'hB000_0000 | {26'd0, bus.prf_rs2_idx};

    typedef struct {
        logic        fl;
        logic        dv;
        br_op_e      op;
        logic [31:0] pc;
        logic [5:0]  rs1;
        logic        r1;
        logic [5:0]  rs2;
        logic        r2;
        logic        cv;
        logic [1:0]  cp;
        logic [5:0]  cphy;
        logic        fr;
        logic        ev;
        logic        edr;
        logic [2:0]  ecnt;
        logic [31:0] epc;
        logic [5:0]  ers1;
        logic [5:0]  ers2;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic fl, input logic dv, input br_op_e op, input logic [31:0] pc,
                       input logic [5:0] rs1, input logic r1, input logic [5:0] rs2, input logic r2,
                       input logic cv, input logic [1:0] cp, input logic [5:0] cphy, input logic fr,
                       input logic ev, input logic edr, input logic [2:0] ecnt,
                       input logic [31:0] epc, input logic [5:0] ers1, input logic [5:0] ers2);
        vec_t v;
        v.fl = fl; v.dv = dv; v.op = op; v.pc = pc; v.rs1 = rs1; v.r1 = r1; v.rs2 = rs2; v.r2 = r2;
        v.cv = cv; v.cp = cp; v.cphy = cphy; v.fr = fr;
        v.ev = ev; v.edr = edr; v.ecnt = ecnt; v.epc = epc; v.ers1 = ers1; v.ers2 = ers2;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic fr, input logic ev, input logic [2:0] ecnt,
                        input logic [31:0] epc, input logic [5:0] ers1, input logic [5:0] ers2);
        add(1'b0, 1'b0, BR_BEQ, 32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 6'd0, fr,
            ev, 1'b1, ecnt, epc, ers1, ers2);
    endtask

    task automatic disp(input br_op_e op, input logic [31:0] pc, input logic [5:0] rs1, input logic r1,
                        input logic [5:0] rs2, input logic r2, input logic fr,
                        input logic ev, input logic edr, input logic [2:0] ecnt,
                        input logic [31:0] epc, input logic [5:0] ers1, input logic [5:0] ers2);
        add(1'b0, 1'b1, op, pc, rs1, r1, rs2, r2, 1'b0, 2'd0, 6'd0, fr,
            ev, edr, ecnt, epc, ers1, ers2);
    endtask

    task automatic check(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, step, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        br_uop_t                u;
        logic [4*PRF_IDX_W-1:0] phy;
        logic [3:0]             cvld;
        u                = '0;
        u.rob_id         = v.pc[6:2];
        u.rd_arch        = 5'd1;
        u.rd_phy         = 6'd33;
        u.rs1_phy        = v.rs1;
        u.rs2_phy        = v.rs2;
        u.rs1_rdy        = v.r1;
        u.rs2_rdy        = v.r2;
        u.fu_opcode      = v.op;
        u.imm            = 32'h10;
        u.pc             = v.pc;
        u.predict_taken  = 1'b0;
        u.predict_target = v.pc + 32'h4;
        phy  = '0;
        cvld = '0;
        if (v.cv) begin
            cvld[v.cp]                   = 1'b1;
            phy[v.cp*PRF_IDX_W +: PRF_IDX_W] = v.cphy;
        end
        bus.flush          = v.fl;
        bus.dispatch_valid = v.dv;
        bus.dispatch_uop   = u;
        bus.cdb_valid      = cvld;
        bus.cdb_rd_phy     = phy;
        bus.fu_br_ready    = v.fr;
    endtask

    task automatic check_row(input vec_t v, input int step);
        check("br_rs_valid", step, {31'd0, bus.br_rs_valid}, {31'd0, v.ev});
        check("dispatch_ready", step, {31'd0, bus.dispatch_ready}, {31'd0, v.edr});
        check("count", step, {29'd0, dut.count}, {29'd0, v.ecnt});
        if (v.ev) begin
            check("out_pc", step, bus.fu_br_reg_out.pc, v.epc);
            check("prf_rs1_idx", step, {26'd0, bus.prf_rs1_idx}, {26'd0, v.ers1});
            check("prf_rs2_idx", step, {26'd0, bus.prf_rs2_idx}, {26'd0, v.ers2});
            check("rs1_value", step, bus.fu_br_reg_out.rs1_value, 32'hA000_0000 | {26'd0, v.ers1});
            check("rs2_value", step, bus.fu_br_reg_out.rs2_value, 32'hB000_0000 | {26'd0, v.ers2});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        bus.dispatch_uop   = '0;
        bus.cdb_valid      = '0;
        bus.cdb_rd_phy     = '0;
        bus.fu_br_ready    = 1'b0;

        // Single ready BEQ: offered the next cycle, held while fu_br stalls, retired on ready.
        disp(BR_BEQ,  32'h1000, 6'd3, 1'b1, 6'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        idle(1'b0, 1'b1, 3'd1, 32'h1000, 6'd3, 6'd5);
        idle(1'b1, 1'b1, 3'd1, 32'h1000, 6'd3, 6'd5);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        // BNE waits on phy 7 (rs2 is phy 0), broadcast two cycles after dispatch.
        disp(BR_BNE,  32'h2000, 6'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b0, 3'd1, 32'h0, 6'd0, 6'd0);
        add(1'b0, 1'b0, BR_BEQ, 32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 2'd1, 6'd7, 1'b1,
            1'b0, 1'b1, 3'd1, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b1, 3'd1, 32'h2000, 6'd7, 6'd0);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        // Same-cycle wakeup on CDB port 2 while dispatching.
        add(1'b0, 1'b1, BR_BLT, 32'h3000, 6'd4, 1'b1, 6'd9, 1'b0, 1'b1, 2'd2, 6'd9, 1'b1,
            1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b1, 3'd1, 32'h3000, 6'd4, 6'd9);
        // Head waits on phy 12 and blocks a ready JAL; an unrelated broadcast wakes nothing.
        disp(BR_BGE,  32'h4000, 6'd12, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        add(1'b0, 1'b1, BR_JAL, 32'h4004, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 2'd0, 6'd13, 1'b1,
            1'b0, 1'b1, 3'd1, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b0, 3'd2, 32'h0, 6'd0, 6'd0);
        add(1'b0, 1'b0, BR_BEQ, 32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 2'd3, 6'd12, 1'b1,
            1'b0, 1'b1, 3'd2, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b1, 3'd2, 32'h4000, 6'd12, 6'd1);
        idle(1'b1, 1'b1, 3'd1, 32'h4004, 6'd0, 6'd0);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        // Fill to DEPTH, stall while full, then ten uops back to back through the wrap.
        disp(BR_BEQ,  32'h5000, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        disp(BR_BEQ,  32'h5004, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 32'h5000, 6'd1, 6'd2);
        disp(BR_BEQ,  32'h5008, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 32'h5000, 6'd1, 6'd2);
        disp(BR_BEQ,  32'h500C, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 32'h5000, 6'd1, 6'd2);
        disp(BR_BEQ,  32'h5010, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 32'h5000, 6'd1, 6'd2);
        disp(BR_BEQ,  32'h5010, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h5004, 6'd1, 6'd2);
        disp(BR_BNE,  32'h5014, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h5008, 6'd1, 6'd2);
        disp(BR_BLTU, 32'h5018, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h500C, 6'd1, 6'd2);
        disp(BR_BGEU, 32'h501C, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h5010, 6'd1, 6'd2);
        disp(BR_JALR, 32'h5020, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h5014, 6'd1, 6'd2);
        disp(BR_JAL,  32'h5024, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 32'h5018, 6'd1, 6'd2);
        idle(1'b1, 1'b1, 3'd3, 32'h501C, 6'd1, 6'd2);
        idle(1'b1, 1'b1, 3'd2, 32'h5020, 6'd1, 6'd2);
        idle(1'b1, 1'b1, 3'd1, 32'h5024, 6'd1, 6'd2);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        // Flush with three entries, a dispatch and a wakeup in the same cycle.
        disp(BR_BEQ,  32'h6000, 6'd15, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        disp(BR_BEQ,  32'h6004, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'h0, 6'd0, 6'd0);
        disp(BR_BEQ,  32'h6008, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'h0, 6'd0, 6'd0);
        add(1'b1, 1'b1, BR_BEQ, 32'h600C, 6'd1, 1'b1, 6'd2, 1'b1, 1'b1, 2'd0, 6'd15, 1'b1,
            1'b0, 1'b1, 3'd3, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        add(1'b0, 1'b0, BR_BEQ, 32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 2'd0, 6'd15, 1'b1,
            1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        // Flush while the head is being offered, then normal operation resumes.
        disp(BR_JAL,  32'h7000, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        add(1'b1, 1'b0, BR_BEQ, 32'h0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1,
            1'b0, 1'b1, 3'd1, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);
        disp(BR_BEQ,  32'h7004, 6'd8, 1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 6'd0, 6'd0);
        idle(1'b1, 1'b1, 3'd1, 32'h7004, 6'd8, 6'd10);
        idle(1'b1, 1'b0, 3'd0, 32'h0, 6'd0, 6'd0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", -1, {31'd0, bus.br_rs_valid}, 32'd0);
        check("reset_dready", -1, {31'd0, bus.dispatch_ready}, 32'd1);
        check("reset_count", -1, {29'd0, dut.count}, 32'd0);

        for (int s = 0; s < tbl.size(); s++) begin
            @(negedge clk);
            apply(tbl[s]);
            #1;
            check_row(tbl[s], s);
        end

        // Synchronous reset in the middle of traffic drops the offered entry.
        @(negedge clk);
        apply(tbl[0]);
        bus.dispatch_uop.pc = 32'h8000;
        @(negedge clk);
        bus.dispatch_valid = 1'b0;
        bus.fu_br_ready    = 1'b0;
        #1;
        check("pre_rst_valid", 1000, {31'd0, bus.br_rs_valid}, 32'd1);
        check("pre_rst_pc", 1000, bus.fu_br_reg_out.pc, 32'h8000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_valid", 1001, {31'd0, bus.br_rs_valid}, 32'd0);
        check("post_rst_dready", 1001, {31'd0, bus.dispatch_ready}, 32'd1);
        check("post_rst_count", 1001, {29'd0, dut.count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
